// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI arbiter: FSM states, length codes, default watchdog limit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_XFER  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   localparam logic [1:0] LEN_8  = 2'd0;
   localparam logic [1:0] LEN_16 = 2'd1;
   localparam logic [1:0] LEN_24 = 2'd2;
   localparam logic [1:0] LEN_32 = 2'd3;

   localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/spi_rr_picker.sv
// Round-robin pick: first set req bit scanning upward from ptr, wrapping modulo N_REQ.
// Latency: combinational.
// Backpressure: none; found=0 when req is empty.
module spi_rr_picker #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         gnt_next,
   output logic [$clog2(N_REQ)-1:0] index,
   output logic                     found
);

   localparam int IDX_W = $clog2(N_REQ);

   int slot;

   always_comb begin
      gnt_next = '0;
      index    = '0;
      found    = 1'b0;
      slot     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         slot = int'(ptr) + k;
         if (slot >= N_REQ) slot = slot - N_REQ;
         if (!found && req[IDX_W'(slot)]) begin
            found                    = 1'b1;
            index                    = IDX_W'(slot);
            gnt_next[IDX_W'(slot)]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin share of one spi_master among N_REQ requesters; optional busy watchdog under SPI_ARB_TIMEOUT_EN.
// Latency: spi_start in the cycle after req is sampled in IDLE; done one cycle after spi_busy falls.
// Backpressure: requesters hold req until done; arbitration stalls while spi_busy is high in IDLE.
module spi_arbiter
   import spi_arb_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ*32-1:0]  req_tx_data,
   input  logic [N_REQ*3-1:0]   req_chip,
   input  logic [N_REQ*2-1:0]   req_len,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     done,
   output logic [31:0]          rx_data,
   output logic                 err,
   output logic                 spi_start,
   input  logic                 spi_busy,
   output logic [31:0]          spi_tx_data,
   input  logic [31:0]          spi_rx_data,
   output logic [2:0]           spi_chip,
   output logic [1:0]           spi_len
);

   localparam int IDX_W = $clog2(N_REQ);

   arb_state_t       state, state_nx;
   logic [IDX_W-1:0] ptr, g_idx, pick_idx;
   logic [N_REQ-1:0] pick_gnt;
   logic             pick_found;
   logic             timeout;
   logic [31:0]      sel_tx;
   logic [2:0]       sel_chip;
   logic [1:0]       sel_len;
   logic             grant_now, done_now;

   spi_rr_picker #(.N_REQ(N_REQ)) u_picker (
      .req      (req),
      .ptr      (ptr),
      .gnt_next (pick_gnt),
      .index    (pick_idx),
      .found    (pick_found)
   );

   always_comb begin
      sel_tx   = '0;
      sel_chip = '0;
      sel_len  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick_gnt[k]) begin
            sel_tx   = req_tx_data[k*32 +: 32];
            sel_chip = req_chip[k*3 +: 3];
            sel_len  = req_len[k*2 +: 2];
         end
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   logic [31:0] to_cnt;

   // Cleared while IDLE/DONE, so it starts from zero on every entry to START.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         to_cnt <= '0;
      else if (state == ST_START || state == ST_XFER)
         to_cnt <= to_cnt + 32'd1;
      else
         to_cnt <= '0;
   end

   assign timeout = (state == ST_START || state == ST_XFER) &&
                    (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   wire unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:  if (pick_found && !spi_busy) state_nx = ST_START;
         ST_START: if (timeout) state_nx = ST_DONE;
                   else if (spi_busy) state_nx = ST_XFER;
         ST_XFER:  if (timeout || !spi_busy) state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   assign grant_now = (state == ST_IDLE) && (state_nx == ST_START);
   assign done_now  = (state != ST_DONE) && (state_nx == ST_DONE);

   // Config is captured only at grant, so req_* changes mid-transfer have no effect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt         <= '0;
         g_idx       <= '0;
         ptr         <= '0;
         done        <= '0;
         err         <= 1'b0;
         rx_data     <= '0;
         spi_start   <= 1'b0;
         spi_tx_data <= '0;
         spi_chip    <= '0;
         spi_len     <= '0;
      end else begin
         done <= '0;
         err  <= 1'b0;
         if (grant_now) begin
            gnt         <= pick_gnt;
            g_idx       <= pick_idx;
            spi_tx_data <= sel_tx;
            spi_chip    <= sel_chip;
            spi_len     <= sel_len;
            spi_start   <= 1'b1;
         end
         if (state == ST_START && state_nx != ST_START)
            spi_start <= 1'b0;
         if (done_now) begin
            done    <= gnt;
            err     <= timeout;
            rx_data <= timeout ? 32'd0 : spi_rx_data;
            ptr     <= (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
         end
         if (state == ST_DONE)
            gnt <= '0;
      end
   end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares one spi_master between N_REQ requesters using round-robin arbitration.
- Latches the winning requester's transaction config: tx data, chip address, length code.
- Pulses the master's start, tracks its busy, then returns the received word with a one-cycle done to the granted requester.
- Sits between the user-side logic blocks and spi_master. The master's CPOL, clock divider and default value stay static and are outside this block.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- TIMEOUT_CYCLES, 1024, busy watchdog limit in clk cycles; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester transfer request (level).
- req_tx_data  in  N_REQ*32  packed tx words; slot i = bits [32i+31:32i].
- req_chip  in  N_REQ*3  packed chip addresses.
- req_len  in  N_REQ*2  packed length codes: 0=8b, 1=16b, 2=24b, 3=32b.
- gnt  out  N_REQ  one-hot grant, held for the whole transaction.
- done  out  N_REQ  one-hot, one-cycle completion pulse.
- rx_data  out  32  last received word; valid when any done bit is high, held until the next completion.
- err  out  1  one-cycle timeout pulse, coincident with done.
- spi_start  out  1  to master start_trans.
- spi_busy  in  1  from master busy.
- spi_tx_data  out  32  to master tx_data.
- spi_rx_data  in  32  from master rx_data.
- spi_chip  out  3  to master chip address.
- spi_len  out  2  to master transaction_length.

Behaviour:
- Reset values: gnt=0, done=0, err=0, spi_start=0, spi_tx_data=0, spi_chip=0, spi_len=0, rx_data=0, rr pointer=0, FSM=IDLE.
- IDLE:
  - If req is nonzero, select the first set bit scanning from ptr upward, wrapping modulo N_REQ.
  - Register gnt, spi_tx_data, spi_chip and spi_len from that slot, then go to START.
  - If req is zero, stay in IDLE.
- START: spi_start=1. Go to XFER on the first cycle spi_busy=1. spi_start stays high until that cycle, then drops (registered, so low from the next cycle).
- XFER: wait for spi_busy=0, then go to DONE.
- DONE (1 cycle):
  - rx_data <= spi_rx_data; done[g]=1.
  - ptr <= (g+1) mod N_REQ.
  - Clear gnt, then return to IDLE.
- Latency:
  - req to spi_start: 2 cycles (IDLE sample, START).
  - busy falling to done: 1 cycle.
  - A new grant can issue no earlier than the cycle after DONE.
- Config outputs are stable from START through DONE. Changes on req_* inputs during a transaction are ignored.
- Dropping req mid-transaction does not abort it; done still pulses. Requesters hold req until done, then drop it or keep it asserted to queue another transfer.
- Simultaneous requests are served in round-robin order: with all bits set and ptr=0, grants go 0,1,2,3,0.
- A requester re-asserting req in its own DONE cycle is lowest priority on the next arbitration.
- spi_busy high while in IDLE (master still busy from before reset) blocks the grant. IDLE arbitrates only when spi_busy=0.
- rst during any state returns everything to reset values immediately; no done is issued. The master shares the same rst.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to START and increments in START and XFER.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to DONE with err=1, rx_data <= 0, spi_start low, and the pointer advances as normal.
- Undefined: no counter; the FSM waits indefinitely and err is tied 0.

Decomposition:
- Package spi_arb_pkg: FSM state encoding (IDLE, START, XFER, DONE), length-code constants LEN_8..LEN_32, default TIMEOUT_CYCLES.
- One sub-module, spi_rr_picker: combinational round-robin pick. Inputs req and ptr; outputs one-hot gnt_next and index. Reused by other shared-resource arbiters.

Test Plan:
- Single request: req=0001, tx=0xCA, chip=0, len=0, MISO looped to MOSI. Expect spi_start 2 cycles later; done[0] pulses once 1 cycle after busy falls; rx_data=0x000000CA; gnt=0 afterwards.
- Contention: req=1111 held with distinct tx words 0x11,0x22,0x33,0x44. Expect done order 0,1,2,3,0 and each rx_data matching its requester's word.
- Length/config: requester 2, tx=0x9602C5CA, chip=5, len=3. Expect spi_chip=5, spi_len=3 throughout, rx_data=0x9602C5CA, and req_* changes mid-transfer ignored.
- Request withdrawn: req[1] dropped 3 cycles after grant. Expect the transfer to complete and done[1] to still pulse.
- Reset mid-transaction: assert rst in XFER. Expect all outputs 0 asynchronously, no done pulse, and ptr=0 so the next grant goes to the lowest set req.
- Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): hold spi_busy high. Expect done and err together after 16 cycles, rx_data=0, and the next requester granted.
